// File: rtl/sfi_pipe_bridge.sv
// SFI request/response pipe bridge: registered FIFOs on both paths,
// per-message outstanding count with limit, optional underflow flag.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s_req_*           upstream request in  (vld/rdy/last/pld)
//   m_req_*           downstream request out
//   m_rsp_*           downstream response in
//   s_rsp_*           upstream response out
//   out_cnt           outstanding-message count
//   idle              both FIFOs empty and out_cnt==0
//   err               sticky response-underflow flag
// Macro SFI_PIPE_BRIDGE_ERR_EN enables the err flag; otherwise err=0.

module sfi_pipe_bridge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // explicit wrap so non-power-of-two depths work
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop)  rd_ptr <= nxt(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

module sfi_pipe_bridge #(
   parameter int REQ_W     = 176,
   parameter int RSP_W     = 104,
   parameter int REQ_DEPTH = 2,
   parameter int RSP_DEPTH = 2,
   parameter int MAX_OUT   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_req_vld,
   output logic             s_req_rdy,
   input  logic             s_req_last,
   input  logic [REQ_W-1:0] s_req_pld,
   output logic             m_req_vld,
   input  logic             m_req_rdy,
   output logic             m_req_last,
   output logic [REQ_W-1:0] m_req_pld,
   input  logic             m_rsp_vld,
   output logic             m_rsp_rdy,
   input  logic             m_rsp_last,
   input  logic [RSP_W-1:0] m_rsp_pld,
   output logic             s_rsp_vld,
   input  logic             s_rsp_rdy,
   output logic             s_rsp_last,
   output logic [RSP_W-1:0] s_rsp_pld,
   output logic [7:0]       out_cnt,
   output logic             idle,
   output logic             err
);
   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t state;
   state_t state_nxt;
   logic   alive;
   logic   req_full, req_empty;
   logic   rsp_full, rsp_empty;
   logic   req_acc;
   logic   rsp_last_hs;
   logic   inc, dec;
   logic   at_limit;

   // holds both rdy outputs low through reset and releases them
   // on the first edge after rst_n deasserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   assign at_limit  = (out_cnt == 8'(MAX_OUT));
   // limit only gates message starts, so a burst is never split
   assign s_req_rdy = alive & ~req_full &
                      ((state == ST_BURST) | ~at_limit);
   assign req_acc   = s_req_vld & s_req_rdy;
   assign m_req_vld = ~req_empty;
   assign m_rsp_rdy = alive & ~rsp_full;
   assign s_rsp_vld = ~rsp_empty;

   sfi_pipe_bridge_fifo #(.W(REQ_W + 1), .DEPTH(REQ_DEPTH)) u_req (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_acc),
      .din   ({s_req_last, s_req_pld}),
      .pop   (m_req_rdy),
      .dout  ({m_req_last, m_req_pld}),
      .full  (req_full),
      .empty (req_empty)
   );

   sfi_pipe_bridge_fifo #(.W(RSP_W + 1), .DEPTH(RSP_DEPTH)) u_rsp (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (m_rsp_vld & m_rsp_rdy),
      .din   ({m_rsp_last, m_rsp_pld}),
      .pop   (s_rsp_rdy),
      .dout  ({s_rsp_last, s_rsp_pld}),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      inc       = 1'b0;
      unique case (1'b1)
         (state == ST_IDLE): begin
            inc = req_acc;
            if (req_acc && !s_req_last) state_nxt = ST_BURST;
         end
         (state == ST_BURST): begin
            if (req_acc && s_req_last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rsp_last_hs = s_rsp_vld & s_rsp_rdy & s_rsp_last;
   assign dec         = rsp_last_hs & (out_cnt != 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt <= 8'd0;
      end else begin
         unique case ({inc, dec})
            2'b10:   out_cnt <= out_cnt + 8'd1;
            2'b01:   out_cnt <= out_cnt - 8'd1;
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   assign idle = req_empty & rsp_empty & (out_cnt == 8'd0);

`ifdef SFI_PIPE_BRIDGE_ERR_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           err_q <= 1'b0;
      else if (rsp_last_hs && !(|out_cnt)) err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule
